csr_wr_sched: RTL and testbench

Single-write-port scheduler for the CSR register file. It sits between the EXE-stage CSR functional unit, the WB stage, the trap unit and the debug port. It decides each cycle which requester owns the CSR write port and sequences the four-register trap-entry write burst. It also keeps a small in-order scoreboard of CSR writes still in flight, and drives `csr_rd_avail` back to the CSR functional unit so that a read never sees a stale value.

---
 rtl/csr_wr_sched_pkg.sv | 21 ++
 rtl/csr_pend_fifo.sv | 87 ++++++++
 rtl/csr_wr_sched.sv | 207 ++++++++++++++++++++
 tb/tb_csr_wr_sched.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_wr_sched_pkg.sv
// Shared CSR definitions for the write-port scheduler: the machine-mode trap
// CSR addresses and the trap-entry sequencer state encoding.
package csr_wr_sched_pkg;

    localparam int CSR_AW = 12;

    localparam logic [CSR_AW-1:0] CSR_MSTATUS = 12'h300;
    localparam logic [CSR_AW-1:0] CSR_MEPC    = 12'h341;
    localparam logic [CSR_AW-1:0] CSR_MCAUSE  = 12'h342;
    localparam logic [CSR_AW-1:0] CSR_MTVAL   = 12'h343;

    typedef enum logic [2:0] {
        IDLE,
        W_MEPC,
        W_MCAUSE,
        W_MTVAL,
        W_MSTATUS,
        DONE
    } trap_state_e;

endpackage

// File: rtl/csr_pend_fifo.sv
// In-order FIFO of CSR addresses with writes still in flight between EXE and
// WB. Every valid entry is compared against cmp_addr in parallel so the
// scheduler can flag read-after-write hazards in a single cycle.
module csr_pend_fifo #(
    parameter int DEPTH = 2,
    parameter int AW    = 12
) (
    input  logic          clk_in,
    input  logic          reset_in,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [AW-1:0] push_addr,
    input  logic [AW-1:0] cmp_addr,
    output logic [AW-1:0] head_addr,
    output logic          full,
    output logic          empty,
    output logic          match
);

    localparam int PW = $clog2(DEPTH);

    logic [AW-1:0]    mem [DEPTH];
    logic [DEPTH-1:0] valid;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             push_en;
    logic             pop_en;

    assign full      = &valid;
    assign empty     = ~|valid;
    assign head_addr = mem[rd_ptr];

    // A pop frees the head in the same cycle, so a push into a full FIFO is
    // legal when it coincides with a pop. Flush wins over a same-cycle push.
    assign pop_en  = pop & ~empty;
    assign push_en = push & ~flush & (~full | pop_en);

    // Pointer and valid-bit update; the push assignment follows the pop so a
    // full-FIFO swap on the same slot leaves it valid.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            valid  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            valid  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (pop_en) begin
                valid[rd_ptr] <= 1'b0;
                rd_ptr        <= rd_ptr + PW'(1);
            end
            if (push_en) begin
                valid[wr_ptr] <= 1'b1;
                wr_ptr        <= wr_ptr + PW'(1);
            end
        end
    end

    // Address storage.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push_en) begin
            mem[wr_ptr] <= push_addr;
        end
    end

    // Parallel hazard compare across all valid entries.
    always_comb begin
        match = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i] && (mem[i] == cmp_addr)) begin
                match = 1'b1;
            end
        end
    end

    // Upstream must stall rather than push into a full FIFO.
    a_no_overflow: assert property (@(posedge clk_in) disable iff (reset_in)
        !(push && !flush && full && !pop_en));

endmodule

// File: rtl/csr_wr_sched.sv
// CSR write-port scheduler: arbitrates trap burst > WB > debug onto a single
// registered write port, and tracks in-flight CSR writes for read hazards.
//
// Trap-entry FSM
//   state     | meaning
//   IDLE      | no burst; trap_req is accepted and operands captured
//   W_MEPC    | issue write of captured pc to mepc
//   W_MCAUSE  | issue write of captured cause to mcause
//   W_MTVAL   | issue write of captured tval to mtval
//   W_MSTATUS | issue write of captured mstatus to mstatus
//   DONE      | trap_done pulse; port is free again for WB/debug
module csr_wr_sched
    import csr_wr_sched_pkg::*;
#(
    parameter int RSZ        = 32,
    parameter int PEND_DEPTH = 2
) (
    input  logic              clk_in,
    input  logic              reset_in,
    input  logic [CSR_AW-1:0] exe_csr_addr,
    input  logic              exe_is_csr,
    input  logic              exe_csr_wr,
    input  logic              exe_adv,
    input  logic              flush,
    output logic              csr_rd_avail,
    input  logic              wb_req,
    input  logic [CSR_AW-1:0] wb_addr,
    input  logic [RSZ-1:0]    wb_data,
    output logic              wb_gnt,
    input  logic              trap_req,
    input  logic [RSZ-1:0]    trap_pc,
    input  logic [RSZ-1:0]    trap_cause,
    input  logic [RSZ-1:0]    trap_tval,
    input  logic [RSZ-1:0]    trap_mstatus,
    output logic              trap_busy,
    output logic              trap_done,
    input  logic              dbg_req,
    input  logic [CSR_AW-1:0] dbg_addr,
    input  logic [RSZ-1:0]    dbg_data,
    output logic              dbg_gnt,
    output logic              csr_we,
    output logic [CSR_AW-1:0] csr_waddr,
    output logic [RSZ-1:0]    csr_wdata
);

    trap_state_e       state_q;
    trap_state_e       state_d;
    logic [RSZ-1:0]    pc_q;
    logic [RSZ-1:0]    cause_q;
    logic [RSZ-1:0]    tval_q;
    logic [RSZ-1:0]    mstatus_q;
    logic              trap_accept;
    logic              trap_wr;
    logic [CSR_AW-1:0] trap_waddr;
    logic [RSZ-1:0]    trap_wdata;
    logic              gnt_block;
    logic              wr_en_d;
    logic [CSR_AW-1:0] waddr_d;
    logic [RSZ-1:0]    wdata_d;
    logic              fifo_push;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_match;
    logic [CSR_AW-1:0] fifo_head;

    assign trap_accept = (state_q == IDLE) && trap_req;
    assign trap_busy   = (state_q != IDLE);
    assign trap_done   = (state_q == DONE);

    // The port is reserved from the accept cycle through the last burst
    // write; DONE issues no write, so grants resume there.
    assign gnt_block = trap_accept | trap_wr;
    assign wb_gnt    = wb_req & ~gnt_block;
    assign dbg_gnt   = dbg_req & ~gnt_block & ~wb_req;

    assign fifo_push = exe_is_csr & exe_csr_wr & exe_adv;

    // Trap FSM state register.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Trap FSM next state and the burst write for the current state.
    always_comb begin
        state_d    = state_q;
        trap_wr    = 1'b0;
        trap_waddr = '0;
        trap_wdata = '0;
        case (state_q)
            IDLE: begin
                if (trap_req) state_d = W_MEPC;
            end
            W_MEPC: begin
                state_d    = W_MCAUSE;
                trap_wr    = 1'b1;
                trap_waddr = CSR_MEPC;
                trap_wdata = pc_q;
            end
            W_MCAUSE: begin
                state_d    = W_MTVAL;
                trap_wr    = 1'b1;
                trap_waddr = CSR_MCAUSE;
                trap_wdata = cause_q;
            end
            W_MTVAL: begin
                state_d    = W_MSTATUS;
                trap_wr    = 1'b1;
                trap_waddr = CSR_MTVAL;
                trap_wdata = tval_q;
            end
            W_MSTATUS: begin
                state_d    = DONE;
                trap_wr    = 1'b1;
                trap_waddr = CSR_MSTATUS;
                trap_wdata = mstatus_q;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Snapshot trap operands at acceptance so later input changes are ignored.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            pc_q      <= '0;
            cause_q   <= '0;
            tval_q    <= '0;
            mstatus_q <= '0;
        end else if (trap_accept) begin
            pc_q      <= trap_pc;
            cause_q   <= trap_cause;
            tval_q    <= trap_tval;
            mstatus_q <= trap_mstatus;
        end
    end

    // Select the winning write for this cycle.
    always_comb begin
        wr_en_d = 1'b0;
        waddr_d = '0;
        wdata_d = '0;
        if (trap_wr) begin
            wr_en_d = 1'b1;
            waddr_d = trap_waddr;
            wdata_d = trap_wdata;
        end else if (wb_gnt) begin
            wr_en_d = 1'b1;
            waddr_d = wb_addr;
            wdata_d = wb_data;
        end else if (dbg_gnt) begin
            wr_en_d = 1'b1;
            waddr_d = dbg_addr;
            wdata_d = dbg_data;
        end
    end

    // Registered write port; address/data hold their last value when idle.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            csr_we    <= 1'b0;
            csr_waddr <= '0;
            csr_wdata <= '0;
        end else begin
            csr_we <= wr_en_d;
            if (wr_en_d) begin
                csr_waddr <= waddr_d;
                csr_wdata <= wdata_d;
            end
        end
    end

    csr_pend_fifo #(
        .DEPTH (PEND_DEPTH),
        .AW    (CSR_AW)
    ) u_pend_fifo (
        .clk_in    (clk_in),
        .reset_in  (reset_in),
        .push      (fifo_push),
        .pop       (wb_gnt),
        .flush     (flush),
        .push_addr (exe_csr_addr),
        .cmp_addr  (exe_csr_addr),
        .head_addr (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .match     (fifo_match)
    );

    // A read is unsafe while its address is in flight, while the scoreboard
    // cannot track more, during a trap burst, or while the registered write
    // to that address has not yet landed in the CSR file.
    assign csr_rd_avail = ~(fifo_match | fifo_full | trap_busy |
                            (csr_we & (csr_waddr == exe_csr_addr)));

    // WB retires CSR writes strictly in EXE order.
    a_wb_in_order: assert property (@(posedge clk_in) disable iff (reset_in)
        wb_gnt |-> (!fifo_empty && (fifo_head == wb_addr)));

endmodule

// File: tb/tb_csr_wr_sched.sv
module tb_csr_wr_sched;

    localparam int RSZ   = 32;
    localparam int DEPTH = 2;

    logic            clk_in;
    logic            reset_in;
    logic [11:0]     exe_csr_addr;
    logic            exe_is_csr, exe_csr_wr, exe_adv, flush;
    logic            csr_rd_avail;
    logic            wb_req;
    logic [11:0]     wb_addr;
    logic [RSZ-1:0]  wb_data;
    logic            wb_gnt;
    logic            trap_req;
    logic [RSZ-1:0]  trap_pc, trap_cause, trap_tval, trap_mstatus;
    logic            trap_busy, trap_done;
    logic            dbg_req;
    logic [11:0]     dbg_addr;
    logic [RSZ-1:0]  dbg_data;
    logic            dbg_gnt;
    logic            csr_we;
    logic [11:0]     csr_waddr;
    logic [RSZ-1:0]  csr_wdata;

    int n_run  = 0;
    int n_fail = 0;

    csr_wr_sched #(.RSZ(RSZ), .PEND_DEPTH(DEPTH)) dut (
        .clk_in(clk_in), .reset_in(reset_in),
        .exe_csr_addr(exe_csr_addr), .exe_is_csr(exe_is_csr), .exe_csr_wr(exe_csr_wr),
        .exe_adv(exe_adv), .flush(flush), .csr_rd_avail(csr_rd_avail),
        .wb_req(wb_req), .wb_addr(wb_addr), .wb_data(wb_data), .wb_gnt(wb_gnt),
        .trap_req(trap_req), .trap_pc(trap_pc), .trap_cause(trap_cause),
        .trap_tval(trap_tval), .trap_mstatus(trap_mstatus),
        .trap_busy(trap_busy), .trap_done(trap_done),
        .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_data(dbg_data), .dbg_gnt(dbg_gnt),
        .csr_we(csr_we), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_wr(input string name, input logic we, input logic [11:0] a,
                          input logic [31:0] d);
        chk({name, "_we"}, csr_we, we);
        if (we) begin
            chk({name, "_addr"}, csr_waddr, a);
            chk({name, "_data"}, csr_wdata, d);
        end
    endtask

    task automatic clr_inputs();
        exe_csr_addr = '0; exe_is_csr = 0; exe_csr_wr = 0; exe_adv = 0; flush = 0;
        wb_req = 0; wb_addr = '0; wb_data = '0;
        trap_req = 0; trap_pc = '0; trap_cause = '0; trap_tval = '0; trap_mstatus = '0;
        dbg_req = 0; dbg_addr = '0; dbg_data = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk_in);
        #1;
    endtask

    task automatic push_addr(input logic [11:0] a);
        exe_is_csr = 1; exe_csr_wr = 1; exe_adv = 1; exe_csr_addr = a;
    endtask

    typedef struct {
        logic trap_req, wb_req, dbg_req;
        logic exp_wb, exp_dbg;
    } prio_vec_t;

    function automatic bit in_q(input logic [11:0] q[$], input logic [11:0] a);
        foreach (q[i]) if (q[i] == a) return 1;
        return 0;
    endfunction

    initial begin
        prio_vec_t   tbl[8];
        logic [11:0] ea[4];
        logic [31:0] ed[4];
        logic [11:0] pool[4];
        logic [11:0] q[$];
        logic [31:0] tv[4];
        int          acc;
        logic        m_we;
        logic [11:0] m_addr;
        logic [31:0] m_data;
        bit          wb_clear, dbg_clear;

        tbl[0] = '{0, 0, 0, 0, 0};
        tbl[1] = '{0, 0, 1, 0, 1};
        tbl[2] = '{0, 1, 0, 1, 0};
        tbl[3] = '{0, 1, 1, 1, 0};
        tbl[4] = '{1, 0, 0, 0, 0};
        tbl[5] = '{1, 0, 1, 0, 0};
        tbl[6] = '{1, 1, 0, 0, 0};
        tbl[7] = '{1, 1, 1, 0, 0};
        ea = '{12'h341, 12'h342, 12'h343, 12'h300};
        ed = '{32'h100, 32'hB, 32'h0, 32'h1880};
        pool = '{12'h340, 12'h341, 12'h300, 12'h7FF};

        // ---- reset values ----
        reset_in = 1;
        clr_inputs();
        repeat (3) @(posedge clk_in);
        #1;
        chk("rst_we", csr_we, 0);
        chk("rst_waddr", csr_waddr, 0);
        chk("rst_wdata", csr_wdata, 0);
        chk("rst_busy", trap_busy, 0);
        chk("rst_done", trap_done, 0);
        chk("rst_wb_gnt", wb_gnt, 0);
        chk("rst_dbg_gnt", dbg_gnt, 0);
        chk("rst_avail", csr_rd_avail, 1);
        reset_in = 0;

        // ---- priority table (combinational, idle, requests withdrawn before edge) ----
        for (int i = 0; i < 8; i++) begin
            next_cycle();
            trap_req = tbl[i].trap_req; wb_req = tbl[i].wb_req; dbg_req = tbl[i].dbg_req;
            wb_addr = 12'h340; dbg_addr = 12'h7B0;
            #1;
            chk("tbl_wb_gnt", wb_gnt, tbl[i].exp_wb);
            chk("tbl_dbg_gnt", dbg_gnt, tbl[i].exp_dbg);
            chk("tbl_avail", csr_rd_avail, 1);
            clr_inputs();
        end
        next_cycle();
        #1;
        chk("tbl_no_write", csr_we, 0);
        chk("tbl_idle", trap_busy, 0);

        // ---- scoreboard hazard ----
        next_cycle();
        push_addr(12'h340);
        #1 chk("haz_pre", csr_rd_avail, 1);
        next_cycle();
        exe_csr_wr = 0; exe_adv = 0;
        #1 chk("haz_pending", csr_rd_avail, 0);
        exe_csr_addr = 12'h305;
        #1 chk("haz_other", csr_rd_avail, 1);
        exe_csr_addr = 12'h340;
        next_cycle();
        wb_req = 1; wb_addr = 12'h340; wb_data = 32'hDEAD_BEEF;
        #1 chk("haz_gnt", wb_gnt, 1);
        chk("haz_gnt_avail", csr_rd_avail, 0);
        next_cycle();
        wb_req = 0;
        #1 chk_wr("haz_wr", 1, 12'h340, 32'hDEAD_BEEF);
        chk("haz_we_pending", csr_rd_avail, 0);
        next_cycle();
        #1 chk("haz_clear", csr_rd_avail, 1);
        chk("haz_no_we", csr_we, 0);

        // ---- trap burst ----
        next_cycle();
        clr_inputs();
        trap_req = 1; trap_pc = 32'h100; trap_cause = 32'hB; trap_tval = 0; trap_mstatus = 32'h1880;
        #1 chk("trap_acc_busy", trap_busy, 0);
        next_cycle();
        trap_req = 0; trap_pc = '1; trap_cause = '1; trap_tval = '1; trap_mstatus = '1;
        #1 chk("trap_busy", trap_busy, 1);
        chk("trap_we0", csr_we, 0);
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            #1 chk_wr("trap_wr", 1, ea[k], ed[k]);
            chk("trap_done_k", trap_done, (k == 3));
        end
        next_cycle();
        #1 chk("trap_end_busy", trap_busy, 0);
        chk("trap_end_done", trap_done, 0);
        chk("trap_end_we", csr_we, 0);

        // ---- priority with live trap ----
        next_cycle();
        clr_inputs();
        push_addr(12'h340);
        next_cycle();
        clr_inputs();
        trap_req = 1; wb_req = 1; wb_addr = 12'h340; wb_data = 32'hAAAA_0001;
        dbg_req = 1; dbg_addr = 12'h7B0; dbg_data = 32'h1234;
        #1 chk("pri_wb_blk", wb_gnt, 0);
        chk("pri_dbg_blk", dbg_gnt, 0);
        for (int i = 1; i < 5; i++) begin
            next_cycle();
            trap_req = 0;
            #1 chk("pri_wb_blk", wb_gnt, 0);
            chk("pri_dbg_blk", dbg_gnt, 0);
        end
        next_cycle();
        #1 chk("pri_wb_gnt", wb_gnt, 1);
        chk("pri_dbg_wait", dbg_gnt, 0);
        chk("pri_done", trap_done, 1);
        next_cycle();
        wb_req = 0;
        #1 chk("pri_dbg_gnt", dbg_gnt, 1);
        chk_wr("pri_wb_wr", 1, 12'h340, 32'hAAAA_0001);
        next_cycle();
        dbg_req = 0;
        #1 chk_wr("pri_dbg_wr", 1, 12'h7B0, 32'h1234);

        // ---- full FIFO ----
        next_cycle();
        clr_inputs();
        push_addr(12'h340);
        next_cycle();
        push_addr(12'h341);
        next_cycle();
        push_addr(12'h342); wb_req = 1; wb_addr = 12'h340;
        #1 chk("full_avail", csr_rd_avail, 0);
        chk("full_swap_gnt", wb_gnt, 1);
        next_cycle();
        exe_adv = 0; exe_csr_addr = 12'h7FF; wb_addr = 12'h341;
        #1 chk("full_after_swap", csr_rd_avail, 0);
        next_cycle();
        wb_addr = 12'h342;
        #1 chk("full_drain_avail", csr_rd_avail, 1);
        chk("full_drain_gnt", wb_gnt, 1);
        next_cycle();
        clr_inputs();

        // ---- flush ----
        push_addr(12'h340);
        next_cycle();
        push_addr(12'h341);
        next_cycle();
        push_addr(12'h343); flush = 1;
        #1 chk("flush_pre", csr_rd_avail, 0);
        next_cycle();
        clr_inputs();
        exe_is_csr = 1; exe_csr_addr = 12'h340;
        #1 chk("flush_340", csr_rd_avail, 1);
        exe_csr_addr = 12'h343;
        #1 chk("flush_push_dropped", csr_rd_avail, 1);

        // ---- reset mid-burst ----
        next_cycle();
        clr_inputs();
        trap_req = 1; trap_pc = 32'h200; trap_cause = 32'h2; trap_tval = 32'h3; trap_mstatus = 32'h4;
        next_cycle();
        trap_req = 0;
        next_cycle();
        #1 chk_wr("rmb_mepc", 1, 12'h341, 32'h200);
        #1 reset_in = 1;
        #1 chk("rmb_we", csr_we, 0);
        chk("rmb_busy", trap_busy, 0);
        next_cycle();
        reset_in = 0;
        for (int i = 0; i < 6; i++) begin
            next_cycle();
            #1 chk("rmb_no_write", csr_we, 0);
            chk("rmb_idle", trap_busy, 0);
        end

        // ---- randomized run against reference model ----
        clr_inputs();
        acc = -100; m_we = 0; m_addr = '0; m_data = '0;
        wb_clear = 0; dbg_clear = 0;
        for (int c = 0; c < 3000; c++) begin
            bit busy, accept, blocked, e_wb, e_dbg, push, e_avail, e_done;
            int k;
            next_cycle();
            if (wb_clear) wb_req = 0;
            if (dbg_clear) dbg_req = 0;
            exe_csr_addr = pool[$urandom_range(0, 3)];
            exe_is_csr = 1'($urandom_range(0, 1));
            exe_csr_wr = 1'($urandom_range(0, 1));
            exe_adv    = 1'($urandom_range(0, 1));
            flush      = ($urandom_range(0, 19) == 0);
            trap_req   = ($urandom_range(0, 9) == 0);
            trap_pc = $urandom; trap_cause = $urandom; trap_tval = $urandom; trap_mstatus = $urandom;
            if (!wb_req) wb_req = (q.size() != 0) && ($urandom_range(0, 1) == 1);
            else if (q.size() == 0) wb_req = 0;
            if (q.size() != 0) wb_addr = q[0];
            wb_data = $urandom;
            if (!dbg_req && $urandom_range(0, 3) == 0) begin
                dbg_req = 1; dbg_addr = 12'($urandom); dbg_data = $urandom;
            end

            busy    = (c >= acc + 1) && (c <= acc + 5);
            accept  = trap_req && !busy;
            blocked = accept || ((c >= acc + 1) && (c <= acc + 4));
            e_wb    = wb_req && !blocked;
            e_dbg   = dbg_req && !blocked && !wb_req;
            e_done  = (c == acc + 5);
            push    = exe_is_csr && exe_csr_wr && exe_adv;
            if (push && !flush && q.size() == DEPTH && !e_wb) begin
                exe_adv = 0;
                push = 0;
            end
            e_avail = !(in_q(q, exe_csr_addr) || q.size() == DEPTH || busy ||
                        (m_we && m_addr == exe_csr_addr));
            #1;
            chk("rnd_wb_gnt", wb_gnt, e_wb);
            chk("rnd_dbg_gnt", dbg_gnt, e_dbg);
            chk("rnd_busy", trap_busy, busy);
            chk("rnd_done", trap_done, e_done);
            chk("rnd_avail", csr_rd_avail, e_avail);
            chk_wr("rnd_wr", m_we, m_addr, m_data);

            if (accept) begin
                acc = c;
                tv = '{trap_pc, trap_cause, trap_tval, trap_mstatus};
            end
            k = c + 1 - acc;
            if (k >= 2 && k <= 5) begin
                m_we = 1; m_addr = ea[k-2]; m_data = tv[k-2];
            end else if (e_wb) begin
                m_we = 1; m_addr = wb_addr; m_data = wb_data;
            end else if (e_dbg) begin
                m_we = 1; m_addr = dbg_addr; m_data = dbg_data;
            end else begin
                m_we = 0;
            end
            if (flush) q.delete();
            else begin
                if (e_wb) void'(q.pop_front());
                if (push) q.push_back(exe_csr_addr);
            end
            wb_clear  = e_wb;
            dbg_clear = e_dbg;
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
